control_sequencer: RTL
======================

Name: control_sequencer

Overview:
- Multi-cycle microsequencer that drives the memory_system control inputs: it consumes `instruction` and the C/N/P/Z flags and produces the full control word.
- It is the initiator side of the control interface that memory_system responds to.
- It sequences fetch, decode and execute of a 5-bit ISA over the register bank, ALU, MAR, MDR and IR.
- It sits directly above memory_system in the top level.

Parameters:
- DATA_WIDTH, 8, datapath width; passed through for consistency, no width-dependent logic here.
- PC_ADDR, 3'b000, bank address of PC.
- DPTR_ADDR, 3'b001, bank address of DPTR.
- A_ADDR, 3'b010, bank address of A.
- TEMP_ADDR, 3'b011, bank address of TEMP.
- ACC_ADDR, 3'b111, bank address of ACC.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- instruction  in  5  IR contents from memory_system.
- C, N, P, Z  in  1 each  ALU flags from memory_system.
- ir_sclr, mar_sclr  out  1 each  synchronous clear of IR / MAR.
- enaf  out  1  flag register update enable.
- selop  out  3  ALU op: 000 SLL, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 PASS B, 111 INC B.
- shamt  out  2  shift amount.
- bank_wr_en  out  1  register bank write.
- busB_addr, busC_addr  out  3 each  bank read / write address.
- ir_en, mar_en, mdr_en  out  1 each  load enables. MAR loads ALU output; MDR loads memory data.
- wr_rdn  out  1  1 = memory write of ALU output, 0 = read.
- mdr_alu_n  out  1  busC source: 1 = MDR, 0 = ALU.
- halted  out  1  sequencer is in HALT.

Behaviour:
- Clock and reset: single clock; rst is synchronous and active-high.
- Reset: state <= S_CLR.
- Output rule: outputs are decoded combinationally from the state register, plus `instruction` in execute states. Every output not listed for a state is 0.
- S_CLR: ir_sclr=1, mar_sclr=1, all else 0 (this is also the output value while rst is high). Next state S_FA.
- Fetch:
  - S_FA: busB=PC, selop=110, mar_en=1.
  - S_FM: mdr_en=1, wr_rdn=0.
  - S_FI: ir_en=1; busB=PC, selop=111, busC=PC, bank_wr_en=1 (PC+1; wraps 0xFF->0x00).
  - S_DEC: all 0; instruction is stable.
- Decode on instruction[4:3]:
  - 00 ALU: S_EXA: selop=instruction[2:0], busB=A, busC=ACC, shamt=2'b01, enaf=1, bank_wr_en=1. Then S_FA.
  - 01 SHIFT: S_EXA: selop=000, shamt=instruction[1:0], busB=ACC, busC=ACC, enaf=1, bank_wr_en=1; instruction[2] ignored. Then S_FA.
  - 10 memory, instruction[2]=0 LD:
    - S_MA: busB=DPTR, selop=110, mar_en=1.
    - S_MR: mdr_en=1.
    - S_MW: mdr_alu_n=1, busC=ACC, bank_wr_en=1.
    - Then S_FA.
  - 10 memory, instruction[2]=1 ST:
    - S_MA as above.
    - S_MS: busB=ACC, selop=110, wr_rdn=1.
    - Then S_FA.
  - 11 branch:
    - instruction[2]=1 and [1:0]=11: HALT.
    - instruction[2]=1 otherwise: unconditional.
    - instruction[2]=0: condition by [1:0]: 00 Z, 01 C, 10 N, 11 P.
    - Taken: S_BR: busB=TEMP, selop=110, busC=PC, bank_wr_en=1, then S_FA.
    - Not taken: S_DEC goes directly to S_FA.
- Instruction latency in cycles, S_FA through last execute state:
  - ALU / SHIFT: 5.
  - LD: 7.
  - ST: 6.
  - Branch taken: 5.
  - Branch not taken: 4.
- Flags are sampled in S_DEC only. They reflect the last enaf=1 cycle; branches never assert enaf.
- S_HALT: all outputs 0, halted=1. Remains in S_HALT until rst.
- rst in any state, including mid-instruction or S_HALT: S_CLR on the next edge. No partial bank write occurs after the reset edge.
- Reserved fields (ALU/SHIFT instruction[2] where unused, memory instruction[1:0]) are ignored.
- All 32 opcodes are legal; there is no illegal-opcode state.
- Implementation must also be safe for unreachable state encodings: next state S_CLR.

Optional Feature:
- Macro: CU_SINGLE_STEP_EN.
- Defined:
  - Adds ports step (in, 1) and waiting (out, 1).
  - The sequencer holds in S_FA with all outputs 0 and waiting=1 until step=1 is sampled high. The S_FA control word is then driven for one cycle and the instruction proceeds.
  - One instruction executes per step pulse.
  - step held high runs continuously.
- Undefined: no step/waiting ports; S_FA never stalls.

Test Plan:
- rst=1 for 2 cycles, then 0 -> ir_sclr=mar_sclr=1 during rst and the first cycle after; then S_FA control word busB=000, selop=110, mar_en=1.
- instruction=5'b01010 (SLL 2) -> in the 5th cycle of the instruction: selop=000, shamt=10, busB=busC=111, enaf=1, bank_wr_en=1; next cycle mar_en=1 (new fetch).
- instruction=5'b10000 (LD) -> cycle 5 busB=001/mar_en=1; cycle 6 mdr_en=1; cycle 7 mdr_alu_n=1, busC=111, bank_wr_en=1.
- instruction=5'b11000 (JZ): Z=1 -> S_BR with busB=011, busC=000, bank_wr_en=1. Z=0 -> fetch resumes after 4 cycles, no bank write.
- instruction=5'b11111 -> halted=1 and all outputs 0 for 10+ cycles; rst then restores S_CLR.
- rst asserted in S_MR of an LD -> the next cycle shows S_CLR outputs and the S_MW bank write never occurs.

Source files
------------

// File: rtl/control_sequencer.sv
// Microsequencer driving the memory_system control word: fetch/decode/execute of a 5-bit ISA.
// Outputs are combinational from the state (plus instruction/flags in decode/execute); 4-7 cycles per instruction.
// No backpressure; the optional CU_SINGLE_STEP_EN build stalls in S_FA until step is high.
module control_sequencer #(
  parameter int         DATA_WIDTH = 8,
  parameter logic [2:0] PC_ADDR    = 3'b000,
  parameter logic [2:0] DPTR_ADDR  = 3'b001,
  parameter logic [2:0] A_ADDR     = 3'b010,
  parameter logic [2:0] TEMP_ADDR  = 3'b011,
  parameter logic [2:0] ACC_ADDR   = 3'b111
) (
  input  logic       clk,
  input  logic       rst,
`ifdef CU_SINGLE_STEP_EN
  input  logic       step,
  output logic       waiting,
`endif
  input  logic [4:0] instruction,
  input  logic       C,
  input  logic       N,
  input  logic       P,
  input  logic       Z,
  output logic       ir_sclr,
  output logic       mar_sclr,
  output logic       enaf,
  output logic [2:0] selop,
  output logic [1:0] shamt,
  output logic       bank_wr_en,
  output logic [2:0] busB_addr,
  output logic [2:0] busC_addr,
  output logic       ir_en,
  output logic       mar_en,
  output logic       mdr_en,
  output logic       wr_rdn,
  output logic       mdr_alu_n,
  output logic       halted
);

  localparam logic [2:0] OP_SLL    = 3'b000;
  localparam logic [2:0] OP_PASS_B = 3'b110;
  localparam logic [2:0] OP_INC_B  = 3'b111;

  if (DATA_WIDTH < 2) begin : g_bad_width
    $error("control_sequencer: DATA_WIDTH must be at least 2");
  end

  typedef enum logic [3:0] {
    S_CLR  = 4'd0,
    S_FA   = 4'd1,
    S_FM   = 4'd2,
    S_FI   = 4'd3,
    S_DEC  = 4'd4,
    S_EXA  = 4'd5,
    S_MA   = 4'd6,
    S_MR   = 4'd7,
    S_MW   = 4'd8,
    S_MS   = 4'd9,
    S_BR   = 4'd10,
    S_HALT = 4'd11
  } state_t;

  state_t state_q;
  state_t state_d;

  logic br_cond;
  logic br_halt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLR;
    end else begin
      state_q <= state_d;
    end
  end

  // Branch decode: bit 2 selects unconditional, with 111 reserved as HALT.
  always_comb begin
    br_halt = instruction[2] && (instruction[1:0] == 2'b11);
    br_cond = 1'b1;
    if (!instruction[2]) begin
      case (instruction[1:0])
        2'b00:   br_cond = Z;
        2'b01:   br_cond = C;
        2'b10:   br_cond = N;
        default: br_cond = P;
      endcase
    end
  end

  always_comb begin
    state_d    = S_CLR;
    ir_sclr    = 1'b0;
    mar_sclr   = 1'b0;
    enaf       = 1'b0;
    selop      = 3'b000;
    shamt      = 2'b00;
    bank_wr_en = 1'b0;
    busB_addr  = 3'b000;
    busC_addr  = 3'b000;
    ir_en      = 1'b0;
    mar_en     = 1'b0;
    mdr_en     = 1'b0;
    wr_rdn     = 1'b0;
    mdr_alu_n  = 1'b0;
    halted     = 1'b0;
`ifdef CU_SINGLE_STEP_EN
    waiting    = 1'b0;
`endif

    // Reset overrides the decode so no stale write can leak out during the reset cycle.
    if (rst) begin
      ir_sclr  = 1'b1;
      mar_sclr = 1'b1;
      state_d  = S_CLR;
    end else begin
      case (state_q)
        S_CLR: begin
          ir_sclr  = 1'b1;
          mar_sclr = 1'b1;
          state_d  = S_FA;
        end
        S_FA: begin
`ifdef CU_SINGLE_STEP_EN
          if (step) begin
            busB_addr = PC_ADDR;
            selop     = OP_PASS_B;
            mar_en    = 1'b1;
            state_d   = S_FM;
          end else begin
            waiting   = 1'b1;
            state_d   = S_FA;
          end
`else
          busB_addr = PC_ADDR;
          selop     = OP_PASS_B;
          mar_en    = 1'b1;
          state_d   = S_FM;
`endif
        end
        S_FM: begin
          mdr_en  = 1'b1;
          state_d = S_FI;
        end
        S_FI: begin
          ir_en      = 1'b1;
          busB_addr  = PC_ADDR;
          selop      = OP_INC_B;
          busC_addr  = PC_ADDR;
          bank_wr_en = 1'b1;
          state_d    = S_DEC;
        end
        S_DEC: begin
          case (instruction[4:3])
            2'b00, 2'b01: state_d = S_EXA;
            2'b10:        state_d = S_MA;
            default: begin
              if (br_halt) begin
                state_d = S_HALT;
              end else if (br_cond) begin
                state_d = S_BR;
              end else begin
                state_d = S_FA;
              end
            end
          endcase
        end
        S_EXA: begin
          enaf       = 1'b1;
          bank_wr_en = 1'b1;
          busC_addr  = ACC_ADDR;
          if (instruction[3]) begin
            selop     = OP_SLL;
            shamt     = instruction[1:0];
            busB_addr = ACC_ADDR;
          end else begin
            selop     = instruction[2:0];
            shamt     = 2'b01;
            busB_addr = A_ADDR;
          end
          state_d = S_FA;
        end
        S_MA: begin
          busB_addr = DPTR_ADDR;
          selop     = OP_PASS_B;
          mar_en    = 1'b1;
          state_d   = instruction[2] ? S_MS : S_MR;
        end
        S_MR: begin
          mdr_en  = 1'b1;
          state_d = S_MW;
        end
        S_MW: begin
          mdr_alu_n  = 1'b1;
          busC_addr  = ACC_ADDR;
          bank_wr_en = 1'b1;
          state_d    = S_FA;
        end
        S_MS: begin
          busB_addr = ACC_ADDR;
          selop     = OP_PASS_B;
          wr_rdn    = 1'b1;
          state_d   = S_FA;
        end
        S_BR: begin
          busB_addr  = TEMP_ADDR;
          selop      = OP_PASS_B;
          busC_addr  = PC_ADDR;
          bank_wr_en = 1'b1;
          state_d    = S_FA;
        end
        S_HALT: begin
          halted  = 1'b1;
          state_d = S_HALT;
        end
        default: state_d = S_CLR;
      endcase
    end
  end

endmodule
